// File: rtl/inst_mem_pkg.sv
// Shared types, constants and helpers for the instruction-memory responder.
// Contents:
//   state_t / StIdle, StLoad, StReady : responder FSM encoding
//   NOP_WORD                          : addi x0,x0,0, returned when no valid instruction
//   word_index(addr, depth)           : byte address -> word index within the array
//   parity32(data)                    : even-parity bit of a 32-bit word
package inst_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StLoad  = 2'd1;
  localparam state_t StReady = 2'd2;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Drops the byte offset and masks to the array range; depth must be a power of two.
  function automatic int unsigned word_index(input logic [31:0] addr, input int unsigned depth);
    return (addr >> 2) & (depth - 1);
  endfunction

  // Bit that makes the total number of ones in {parity, data} even.
  function automatic logic parity32(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Single write port, single synchronous read port word array.
// Ports:
//   clk_i    : rising-edge clock
//   we_i     : write enable; wdata_i stored at waddr_i
//   waddr_i  : write word address
//   wdata_i  : write data
//   re_i     : read enable; rdata_o updates at the next edge, otherwise holds
//   raddr_i  : read word address
//   rdata_o  : registered read data
// Contents are deliberately not reset so the array maps onto block RAM.
module inst_mem_array #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder for the fetch stage. The program is streamed in
// through the load port, then fetch requests are answered one cycle later.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   inst_mem_read_enable/_addr    : fetch request (byte address)
//   inst_mem_read_data            : instruction word (NOP_WORD when unavailable)
//   inst_mem_read_valid           : read_data answers the previous-cycle request
//   inst_mem_addr_err             : previous request misaligned or out of range
//   load_start                    : pulse, (re)starts a load at word 0
//   load_valid/_data/_last        : load stream, load_last marks the final word
//   load_ready                    : load stream accepted this cycle
//   loaded                        : program present, reads are serviced
//   inst_mem_parity_err           : only with INST_MEM_PARITY_EN; stored parity mismatch
// Build option: define INST_MEM_PARITY_EN to store and check a parity bit per word.
module inst_mem_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = inst_mem_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inst_mem_read_enable,
  input  logic [31:0] inst_mem_read_addr,
  output logic [31:0] inst_mem_read_data,
  output logic        inst_mem_read_valid,
  output logic        inst_mem_addr_err,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        loaded
`ifdef INST_MEM_PARITY_EN
  ,
  output logic        inst_mem_parity_err
`endif
);

  import inst_mem_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef INST_MEM_PARITY_EN
  localparam int unsigned W = 33;
`else
  localparam int unsigned W = 32;
`endif

  state_t      state_q, state_d;
  // One bit wider than the index so it can count all DEPTH words.
  logic [AW:0] wptr_q, wptr_d;

  logic          valid_q, valid_d;
  logic          err_q, err_d;
  // Set when the held response must read as NOP_WORD instead of the array output.
  logic          nop_q, nop_d;

  logic          mem_we;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_re;
  logic [AW-1:0] rd_index;
  logic [31:0]   word_addr;
  logic          rd_req;
  logic          rd_addr_err;
  logic          par_mismatch;

  assign word_addr   = {2'b00, inst_mem_read_addr[31:2]};
  assign rd_addr_err = (inst_mem_read_addr[1:0] != 2'b00) || (word_addr >= DEPTH);
  assign rd_index    = AW'(word_index(inst_mem_read_addr, DEPTH));
  assign rd_req      = inst_mem_read_enable && (state_q == StReady);
  // Only READY reads the array and only LOAD writes it, so the ports never collide.
  assign mem_re      = rd_req && !rd_addr_err;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StLoad;
          wptr_d  = '0;
        end
      end
      StLoad: begin
        if (load_start) begin
          // Restart wins over a transfer offered in the same cycle.
          wptr_d = '0;
        end else if (load_valid) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (load_last || (wptr_q == (AW + 1)'(DEPTH - 1))) begin
            state_d = StReady;
          end
        end
      end
      StReady: begin
        if (load_start) begin
          state_d = StLoad;
          wptr_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = rd_req;
    err_d   = rd_req && rd_addr_err;
    // Without a request the data output keeps its previous value.
    nop_d   = inst_mem_read_enable ? !mem_re : nop_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      nop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      nop_q   <= nop_d;
    end
  end

`ifdef INST_MEM_PARITY_EN
  assign mem_wdata           = {parity32(load_data), load_data};
  assign par_mismatch        = parity32(mem_rdata[31:0]) != mem_rdata[32];
  assign inst_mem_parity_err = valid_q && !err_q && !nop_q && par_mismatch;
`else
  assign mem_wdata    = load_data;
  assign par_mismatch = 1'b0;
`endif

  inst_mem_array #(
    .Depth (DEPTH),
    .Width (W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (rd_index),
    .rdata_o (mem_rdata)
  );

  assign inst_mem_read_data  = (nop_q || par_mismatch) ? NOP_WORD : mem_rdata[31:0];
  assign inst_mem_read_valid = valid_q;
  assign inst_mem_addr_err   = err_q;
  assign load_ready          = (state_q == StLoad);
  assign loaded              = (state_q == StReady);

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench for inst_mem_responder: table-driven read vectors plus
// hand-written load/reset sequences, with expectations queued at drive time.
module tb_inst_mem_responder;

  localparam int unsigned Depth = 1024;
  localparam logic [31:0] Nop   = 32'h0000_0013;
  localparam logic [31:0] Top   = 32'(4 * Depth);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        inst_mem_read_enable = 1'b0;
  logic [31:0] inst_mem_read_addr = '0;
  logic [31:0] inst_mem_read_data;
  logic        inst_mem_read_valid;
  logic        inst_mem_addr_err;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        loaded;
`ifdef INST_MEM_PARITY_EN
  logic        inst_mem_parity_err;
`endif

  always #5 clk = ~clk;

  inst_mem_responder #(
    .DEPTH    (Depth),
    .NOP_WORD (Nop)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .inst_mem_read_enable (inst_mem_read_enable),
    .inst_mem_read_addr   (inst_mem_read_addr),
    .inst_mem_read_data   (inst_mem_read_data),
    .inst_mem_read_valid  (inst_mem_read_valid),
    .inst_mem_addr_err    (inst_mem_addr_err),
    .load_start           (load_start),
    .load_valid           (load_valid),
    .load_data            (load_data),
    .load_last            (load_last),
    .load_ready           (load_ready),
    .loaded               (loaded)
`ifdef INST_MEM_PARITY_EN
    ,
    .inst_mem_parity_err  (inst_mem_parity_err)
`endif
  );

  typedef struct {
    bit          re;
    logic [31:0] addr;
    bit          ls;
    bit          lv;
    bit          ll;
    logic [31:0] ld;
    bit          ev;   // expected valid
    bit          ee;   // expected addr_err
    bit          cd;   // compare data
    logic [31:0] ed;   // expected data
    bit          el;   // expected loaded
    bit          elr;  // expected load_ready
    bit          ep;   // expected parity_err
  } vec_t;

  typedef struct {
    bit          ev;
    bit          ee;
    bit          cd;
    logic [31:0] ed;
    bit          el;
    bit          elr;
    bit          ep;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[12];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic vec_t mk_rd(input logic [31:0] addr, input bit ev, input bit ee,
                                 input logic [31:0] ed, input bit cd, input bit el,
                                 input bit elr);
    vec_t v;
    v = '{re: 1'b1, addr: addr, ls: 1'b0, lv: 1'b0, ll: 1'b0, ld: 32'h0, ev: ev, ee: ee,
          cd: cd, ed: ed, el: el, elr: elr, ep: 1'b0};
    return v;
  endfunction

  function automatic vec_t mk_ld(input bit ls, input bit lv, input bit ll,
                                 input logic [31:0] ld, input bit el, input bit elr);
    vec_t v;
    v = '{re: 1'b0, addr: 32'h0, ls: ls, lv: lv, ll: ll, ld: ld, ev: 1'b0, ee: 1'b0,
          cd: 1'b0, ed: 32'h0, el: el, elr: elr, ep: 1'b0};
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, check it after the edge.
  task automatic step(input vec_t v, input string nm);
    exp_t e;
    inst_mem_read_enable = v.re;
    inst_mem_read_addr   = v.addr;
    load_start           = v.ls;
    load_valid           = v.lv;
    load_last            = v.ll;
    load_data            = v.ld;
    e = '{ev: v.ev, ee: v.ee, cd: v.cd, ed: v.ed, el: v.el, elr: v.elr, ep: v.ep};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({nm, ".valid"}, 32'(inst_mem_read_valid), 32'(e.ev));
    chk({nm, ".err"}, 32'(inst_mem_addr_err), 32'(e.ee));
    chk({nm, ".loaded"}, 32'(loaded), 32'(e.el));
    chk({nm, ".load_ready"}, 32'(load_ready), 32'(e.elr));
    if (e.cd) begin
      chk({nm, ".data"}, inst_mem_read_data, e.ed);
`ifdef INST_MEM_PARITY_EN
      chk({nm, ".parity_err"}, 32'(inst_mem_parity_err), 32'(e.ep));
`endif
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".data"}, inst_mem_read_data, Nop);
    chk({nm, ".valid"}, 32'(inst_mem_read_valid), 32'h0);
    chk({nm, ".err"}, 32'(inst_mem_addr_err), 32'h0);
    chk({nm, ".load_ready"}, 32'(load_ready), 32'h0);
    chk({nm, ".loaded"}, 32'(loaded), 32'h0);
  endtask

  initial begin
    logic [31:0] prog [4];
    logic [31:0] tw [3];
    vec_t        v;
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0063;
    tw[0]   = 32'h00a0_0513;
    tw[1]   = 32'h00b0_0593;
    tw[2]   = 32'h00c0_0613;

    //            addr          ev    ee    data           cd    el    elr
    tbl[0]  = mk_rd(32'h0,      1'b1, 1'b0, prog[0],       1'b1, 1'b1, 1'b0);
    tbl[1]  = mk_rd(32'h4,      1'b1, 1'b0, prog[1],       1'b1, 1'b1, 1'b0);
    tbl[2]  = mk_rd(32'h8,      1'b1, 1'b0, prog[2],       1'b1, 1'b1, 1'b0);
    tbl[3]  = mk_rd(32'hC,      1'b1, 1'b0, prog[3],       1'b1, 1'b1, 1'b0);
    tbl[4]  = mk_rd(32'h0,      1'b0, 1'b0, prog[3],       1'b1, 1'b1, 1'b0);
    tbl[4].re = 1'b0;  // idle cycle: data must hold
    tbl[5]  = mk_rd(32'h6,      1'b1, 1'b1, Nop,           1'b1, 1'b1, 1'b0);
    tbl[6]  = mk_rd(32'h0,      1'b0, 1'b0, Nop,           1'b1, 1'b1, 1'b0);
    tbl[6].re = 1'b0;
    tbl[7]  = mk_rd(Top,        1'b1, 1'b1, Nop,           1'b1, 1'b1, 1'b0);
    tbl[8]  = mk_rd(Top - 4,    1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[9]  = mk_rd(32'h8000_0000, 1'b1, 1'b1, Nop,        1'b1, 1'b1, 1'b0);
    tbl[10] = mk_rd(32'h1,      1'b1, 1'b1, Nop,           1'b1, 1'b1, 1'b0);
    tbl[11] = mk_rd(32'h4,      1'b1, 1'b0, prog[1],       1'b1, 1'b1, 1'b0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reads before any load are not serviced
    for (int i = 0; i < 3; i++) begin
      step(mk_rd(32'h0, 1'b0, 1'b0, Nop, 1'b1, 1'b0, 1'b0), $sformatf("preload%0d", i));
    end

    // Four-word program, last flagged on the fourth
    step(mk_ld(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1), "start");
    for (int i = 0; i < 4; i++) begin
      step(mk_ld(1'b0, 1'b1, i == 3, prog[i], i == 3, i != 3), $sformatf("load%0d", i));
    end

    // Read vectors, including alignment and range boundaries
    for (int i = 0; i < 12; i++) begin
      step(tbl[i], $sformatf("tbl%0d", i));
    end

    // Full-depth load without load_last stops at the last word
    step(mk_ld(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1), "full_start");
    for (int i = 0; i < int'(Depth); i++) begin
      v = mk_ld(1'b0, 1'b1, 1'b0, 32'h1000_0000 + 32'(i), i == int'(Depth) - 1,
                i != int'(Depth) - 1);
      step(v, $sformatf("full%0d", i));
    end
    step(mk_ld(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0), "full_extra");
    step(mk_rd(Top - 4, 1'b1, 1'b0, 32'h1000_03FF, 1'b1, 1'b1, 1'b0), "full_rd_last");
    step(mk_rd(32'h0, 1'b1, 1'b0, 32'h1000_0000, 1'b1, 1'b1, 1'b0), "full_rd_first");

    // Restart mid-load, then a load with load_valid toggling
    step(mk_ld(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1), "tog_start");
    v = mk_ld(1'b0, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);
    v.re = 1'b1;
    v.cd = 1'b1;
    v.ed = Nop;
    step(v, "tog_rd_in_load");
    step(mk_ld(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1), "tog_restart");
    step(mk_ld(1'b0, 1'b1, 1'b0, tw[0], 1'b0, 1'b1), "tog_w0");
    step(mk_ld(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1), "tog_gap0");
    step(mk_ld(1'b0, 1'b1, 1'b0, tw[1], 1'b0, 1'b1), "tog_w1");
    step(mk_ld(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1), "tog_gap1");
    step(mk_ld(1'b0, 1'b1, 1'b1, tw[2], 1'b1, 1'b0), "tog_w2");
    for (int i = 0; i < 3; i++) begin
      step(mk_rd(32'(4 * i), 1'b1, 1'b0, tw[i], 1'b1, 1'b1, 1'b0), $sformatf("tog_rd%0d", i));
    end
    step(mk_rd(32'hC, 1'b1, 1'b0, 32'h1000_0003, 1'b1, 1'b1, 1'b0), "tog_rd3_kept");

    // Reset asserted in the middle of a load
    v = mk_rd(32'h4, 1'b1, 1'b0, tw[1], 1'b1, 1'b0, 1'b1);
    v.ls = 1'b1;
    step(v, "rst_start_rd");
    step(mk_ld(1'b0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1), "rst_w0");
    step(mk_ld(1'b0, 1'b1, 1'b0, 32'h9ABC_DEF0, 1'b0, 1'b1), "rst_w1");
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(mk_rd(32'h0, 1'b0, 1'b0, Nop, 1'b1, 1'b0, 1'b0), "after_reset_rd");

`ifdef INST_MEM_PARITY_EN
    step(mk_ld(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1), "par_start");
    for (int i = 0; i < 3; i++) begin
      step(mk_ld(1'b0, 1'b1, i == 2, tw[i], i == 2, i != 2), $sformatf("par_load%0d", i));
    end
    dut.u_array.mem_q[1][3] = ~dut.u_array.mem_q[1][3];
    step(mk_rd(32'h0, 1'b1, 1'b0, tw[0], 1'b1, 1'b1, 1'b0), "par_rd_ok");
    v = mk_rd(32'h4, 1'b1, 1'b0, Nop, 1'b1, 1'b1, 1'b0);
    v.ep = 1'b1;
    step(v, "par_rd_flip");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Instruction-memory responder serving the fetch stage's `inst_mem_read_enable` / `inst_mem_read_addr` request pair with registered instruction data.
- Holds the program in an internal word array, filled at start-up through a streaming valid/ready load port.
- Sits between the testbench/boot loader and the fetch stage of the single-cycle core.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words; power of two, ≥4.
- NOP_WORD, 32'h00000013, word returned when no valid instruction is available (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- inst_mem_read_enable  in  1  fetch request.
- inst_mem_read_addr  in  32  byte address from the fetch stage.
- inst_mem_read_data  out  32  instruction word.
- inst_mem_read_valid  out  1  read_data holds the response to the previous-cycle request.
- inst_mem_addr_err  out  1  previous request was misaligned or out of range.
- load_start  in  1  pulse; begins a program load at word 0.
- load_valid  in  1  load_data is valid.
- load_data  in  32  instruction word to store.
- load_last  in  1  marks the final word of the load.
- load_ready  out  1  responder accepts load_data this cycle.
- loaded  out  1  program present; reads are serviced.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; write pointer = 0.
  - inst_mem_read_data = NOP_WORD; inst_mem_read_valid = 0; inst_mem_addr_err = 0.
  - load_ready = 0; loaded = 0.
  - Array contents are not cleared.
- FSM states: IDLE, LOAD, READY.
  - IDLE: load_start → LOAD, write pointer = 0.
  - LOAD: load_ready = 1. A transfer occurs when load_valid && load_ready; it writes load_data to mem[wptr] and sets wptr++.
    - A transfer with load_last → READY.
    - A transfer at wptr == DEPTH-1 → READY regardless of load_last; no wrap, no further writes.
  - READY: loaded = 1. load_start → LOAD, wptr = 0, loaded drops the next cycle.
  - load_start in LOAD restarts at wptr = 0; a transfer in that same cycle is discarded.
- Read path, 1-cycle latency; the response is registered at the edge after the request:
  - In READY with read_enable: valid = 1; index = addr[log2(DEPTH)+1:2].
  - err = 1 when addr[1:0] != 0 or addr ≥ 4*DEPTH; data = NOP_WORD when err, else mem[index].
  - Read with read_enable in IDLE or LOAD: valid = 0, data = NOP_WORD, err = 0.
  - No read_enable: valid = 0; data holds its last value; err = 0.
- Read and load never target the array in the same cycle, because reads are only serviced in READY.
- The array is an inferable single write port and single synchronous read port.
- Mid-load reset: returns to IDLE with loaded = 0; partially written contents remain but are unreachable until the next completed load.

Optional Feature:
- INST_MEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed at load time.
  - New output inst_mem_parity_err (1 bit, reset 0) is asserted alongside valid when the stored parity mismatches the read word.
  - On mismatch, data is forced to NOP_WORD.
- Undefined: no parity storage, no port; array is DEPTH×32.

Decomposition:
- Package inst_mem_pkg:
  - FSM state enum (IDLE/LOAD/READY).
  - NOP_WORD constant.
  - Function word_index(addr, depth).
  - Function parity32.
- One sub-module: inst_mem_array (DEPTH × W sync-read RAM, W = 32 or 33), so the responder keeps only FSM, pointer and address checks.

Test Plan:
- Reset then read_enable=1, addr=0 → valid=0, data=32'h00000013, loaded=0 for every cycle before a load.
- load_start; stream 4 words {32'h00500093, 32'h00100113, 32'h002081B3, 32'h00000063}, last on the 4th → loaded=1 one cycle after the last transfer; reads of addr 0/4/8/12 return those words one cycle later with valid=1.
- In READY, addr=32'h00000006 → err=1, data=NOP; addr=4*DEPTH → err=1, data=NOP; addr=4*DEPTH-4 → err=0.
- Load with load_valid toggling every other cycle, 3 words → only handshaked words are written; wptr = 3; loaded=1.
- Deassert reset_n mid-load after 2 words → outputs return to reset values immediately; read while loaded=0 gives valid=0.
- With INST_MEM_PARITY_EN: force a bit flip in the array after load → read gives parity_err=1, data=NOP.
